// File: rtl/fifo_ns.sv
// FIFO control state machine: tracks write/read acceptance against a lagging
// occupancy count, raises status strobes, and counts rejected operations.
module fifo_ns #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [3:0] data_count,
  input  logic       err_clr,
  output logic [2:0] state,
  output logic       full,
  output logic       empty,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       rd_ack,
  output logic       rd_err,
  output logic [7:0] ovf_cnt,
  output logic [7:0] udf_cnt
);

  localparam logic [2:0] INIT     = 3'b000;
  localparam logic [2:0] NO_OP    = 3'b001;
  localparam logic [2:0] WRITE    = 3'b010;
  localparam logic [2:0] WR_ERROR = 3'b011;
  localparam logic [2:0] READ     = 3'b100;
  localparam logic [2:0] RD_ERROR = 3'b101;

  localparam logic [3:0] CAP = 4'(DEPTH);

  logic [2:0] next_state;
  logic [4:0] eff_raw;
  logic [3:0] eff;

  function automatic logic [3:0] clamp_eff(input logic [4:0] v);
    if (v > {1'b0, CAP}) return CAP;
    return v[3:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) return v;
    return v + 8'd1;
  endfunction

  // The count register lags the state by one cycle; fold in the in-flight op.
  always_comb begin
    eff_raw = {1'b0, data_count};
    case (state)
      WRITE:   eff_raw = {1'b0, data_count} + 5'd1;
      READ:    eff_raw = (data_count == 4'd0) ? 5'd0 : {1'b0, data_count} - 5'd1;
      default: eff_raw = {1'b0, data_count};
    endcase
    eff = clamp_eff(eff_raw);
  end

  assign full  = (eff >= CAP);
  assign empty = (eff == 4'd0);

  // Simultaneous requests fall through to NO_OP without counting an error.
  always_comb begin
    next_state = NO_OP;
    case ({wr_en, rd_en})
      2'b10:   next_state = (eff < CAP)   ? WRITE : WR_ERROR;
      2'b01:   next_state = (eff > 4'd0)  ? READ  : RD_ERROR;
      default: next_state = NO_OP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt <= 8'd0;
      udf_cnt <= 8'd0;
    end else if (err_clr) begin
      ovf_cnt <= 8'd0;
      udf_cnt <= 8'd0;
    end else begin
      if (next_state == WR_ERROR) ovf_cnt <= sat_inc(ovf_cnt);
      if (next_state == RD_ERROR) udf_cnt <= sat_inc(udf_cnt);
    end
  end

  assign wr_ack = (state == WRITE);
  assign wr_err = (state == WR_ERROR);
  assign rd_ack = (state == READ);
  assign rd_err = (state == RD_ERROR);

endmodule

// File: tb/tb_fifo_ns.sv
// Bench for fifo_ns: directed corner steps plus random traffic, compared
// against an occupancy-level model of the FIFO.
module tb_fifo_ns;

  localparam int INIT = 0, NO_OP = 1, WRITE = 2, WR_ERROR = 3, READ = 4, RD_ERROR = 5;

  logic       clk;
  logic       reset_n;
  logic       wr_en, rd_en, err_clr;
  logic [3:0] data_count;
  logic [2:0] state;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [7:0] ovf_cnt, udf_cnt;

  fifo_ns #(.DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
    .data_count(data_count), .err_clr(err_clr), .state(state),
    .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: expected state, FIFO count register contents, error tallies.
  int exp_state = INIT;
  int cnt = 0;
  int ovf = 0;
  int udf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(exp_state));
    chk({tag, ".wr_ack"}, 32'(wr_ack), 32'(exp_state == WRITE));
    chk({tag, ".wr_err"}, 32'(wr_err), 32'(exp_state == WR_ERROR));
    chk({tag, ".rd_ack"}, 32'(rd_ack), 32'(exp_state == READ));
    chk({tag, ".rd_err"}, 32'(rd_err), 32'(exp_state == RD_ERROR));
    chk({tag, ".ovf"}, 32'(ovf_cnt), 32'(ovf));
    chk({tag, ".udf"}, 32'(udf_cnt), 32'(udf));
  endtask

  // True occupancy seen by the control logic this cycle.
  function automatic int occupancy(input int st, input int dc);
    int e;
    e = dc;
    if (st == WRITE) e = dc + 1;
    if (st == READ)  e = dc - 1;
    if (e < 0) e = 0;
    if (e > 8) e = 8;
    return e;
  endfunction

  task automatic step(input string tag, input bit w, input bit r, input bit c, input int dc);
    int e;
    int ns;
    @(negedge clk);
    wr_en = w; rd_en = r; err_clr = c; data_count = 4'(dc);
    #1;
    e = occupancy(exp_state, dc);
    chk({tag, ".full"}, 32'(full), 32'(e >= 8));
    chk({tag, ".empty"}, 32'(empty), 32'(e == 0));
    if (w && !r)      ns = (e < 8) ? WRITE : WR_ERROR;
    else if (r && !w) ns = (e > 0) ? READ : RD_ERROR;
    else              ns = NO_OP;
    if (c) begin
      ovf = 0; udf = 0;
    end else begin
      if (ns == WR_ERROR && ovf < 255) ovf++;
      if (ns == RD_ERROR && udf < 255) udf++;
    end
    @(posedge clk);
    if (exp_state == WRITE && cnt < 8) cnt++;
    if (exp_state == READ && cnt > 0) cnt--;
    exp_state = ns;
    #1;
    chk_outputs(tag);
  endtask

  task automatic step_f(input string tag, input bit w, input bit r, input bit c);
    step(tag, w, r, c, cnt);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_count = 4'd0;
    exp_state = INIT; cnt = 0; ovf = 0; udf = 0;
    #1;
    chk_outputs({tag, ".async"});
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_outputs({tag, ".rel"});
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_count = 4'd0;
    #2;
    do_reset("rst0");
    step_f("idle", 0, 0, 0);

    // Fill from empty: 8 accepted then 2 rejected.
    for (int i = 0; i < 10; i++) step_f("fill", 1, 0, 0);
    chk("fill.ovf2", 32'(ovf_cnt), 32'd2);
    step_f("fill.idle", 0, 0, 0);
    chk("fill.full", 32'(full), 32'd1);

    for (int i = 0; i < 8; i++) step_f("drain", 0, 1, 0);
    step_f("under", 0, 1, 0);
    chk("under.rd_err", 32'(rd_err), 32'd1);
    step_f("clr", 0, 0, 1);
    chk("clr.udf", 32'(udf_cnt), 32'd0);

    // Lag-compensation corners with explicit count values.
    step("lag.w", 1, 0, 0, 3);
    step("lag.wfull", 1, 0, 0, 7);
    step("lag.r", 0, 1, 0, 3);
    step("lag.rempty", 0, 1, 0, 1);
    step("both", 1, 1, 0, 4);

    do_reset("rst1");
    for (int i = 0; i < 8; i++) step_f("sat.fill", 1, 0, 0);
    for (int i = 0; i < 300; i++) step_f("sat", 1, 0, 0);
    chk("sat.255", 32'(ovf_cnt), 32'd255);
    step_f("sat.clr", 1, 0, 1);
    chk("sat.clr0", 32'(ovf_cnt), 32'd0);

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      step_f("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 15) == 0));
      if (i == 200) begin
        #2;
        do_reset("rst_mid");
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
